// File: rtl/clock_gen_multi.sv
// rtl/clock_gen_multi.sv - multi-channel clock divider with rise/fall/mid strobes
module clock_gen_multi #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 125,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_p,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      sync_p,
    input  logic [CHANNELS-1:0]       div_wr,
    input  logic [CNT_W-1:0]          div_data,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       rise_tick,
    output logic [CHANNELS-1:0]       fall_tick,
    output logic [CHANNELS-1:0]       mid_tick,
    output logic [CHANNELS*CNT_W-1:0] half_cur
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] wr_val;

    // A zero half-period is meaningless; it is clamped to the fastest rate.
    always_comb wr_val = (div_data == '0) ? CNT_W'(1) : div_data;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] h_q, h_d, p_q, p_d, cnt_q, cnt_d, h_next;
        logic             pend_q, pend_d, en_q, en_d, lvl_q, lvl_d;
        logic             rise_q, rise_d, fall_q, fall_d, mid_q, mid_d;
        logic             restart, toggle;

        always_comb begin
            h_next  = div_wr[i] ? wr_val : (pend_q ? p_q : h_q);
            restart = ch_en[i] && (!en_q || sync_p);
            toggle  = ch_en[i] && !restart && (cnt_q == h_q - CNT_W'(1));
            h_d     = h_q;
            p_d     = p_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            en_d    = ch_en[i];
            lvl_d   = lvl_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            mid_d   = 1'b0;
            // H may only change where the counter restarts, so no half-period is truncated.
            if (!ch_en[i] || restart) begin
                cnt_d  = '0;
                lvl_d  = IDLE_LEVEL;
                h_d    = h_next;
                pend_d = 1'b0;
            end else if (toggle) begin
                cnt_d  = '0;
                lvl_d  = !lvl_q;
                rise_d = !lvl_q;
                fall_d = lvl_q;
                h_d    = h_next;
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                mid_d = (h_q >= CNT_W'(2)) && (cnt_q == (h_q >> 1) - CNT_W'(1));
                if (div_wr[i]) begin
                    p_d    = wr_val;
                    pend_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                h_q    <= DEF_H;
                p_q    <= DEF_H;
                pend_q <= 1'b0;
                cnt_q  <= '0;
                en_q   <= 1'b0;
                lvl_q  <= IDLE_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                mid_q  <= 1'b0;
            end else begin
                h_q    <= h_d;
                p_q    <= p_d;
                pend_q <= pend_d;
                cnt_q  <= cnt_d;
                en_q   <= en_d;
                lvl_q  <= lvl_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                mid_q  <= mid_d;
            end
        end

        assign clk_out[i]                  = lvl_q;
        assign rise_tick[i]                = rise_q;
        assign fall_tick[i]                = fall_q;
        assign mid_tick[i]                 = mid_q;
        assign half_cur[i*CNT_W +: CNT_W]  = h_q;
    end

endmodule

// File: doc/clock_gen_multi.md
# clock_gen_multi

Parametrised, multi-channel successor to the team's fixed-ratio clock divider. Each of `CHANNELS` independent channels divides the system clock by a run-time-loadable half-period and produces:
- a divided clock level;
- single-cycle rise, fall and mid-phase strobes.

The block sits between the system clock and serial engines (I2C SCL generation, DS1302 SCLK, keypad scan, CLCD enable timing). It supplies both the clock waveform and the sample/launch points those engines need. A global sync input re-aligns all channels in phase.

## Interface
- `CHANNELS`, default 2: number of independent divider channels (1..8).
- `CNT_W`, default 16: width of half-period value and internal counter.
- `DEFAULT_HALF`, default 125: reset half-period in `clk` cycles (100 MHz / 400 kHz / 2). Must be 1..2^CNT_W-1.
- `IDLE_LEVEL`, default 0: level of `clk_out` while a channel is disabled or in reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `reset_p`  in  1  asynchronous active-high reset
- `ch_en`  in  CHANNELS  per-channel run enable, level-sensitive
- `sync_p`  in  1  one-cycle pulse that restarts all enabled channels together
- `div_wr`  in  CHANNELS  per-channel write strobe for `div_data`
- `div_data`  in  CNT_W  new half-period H, shared by all channels
- `clk_out`  out  CHANNELS  divided clock level, registered
- `rise_tick`  out  CHANNELS  1-cycle strobe, high in the first cycle `clk_out` is 1
- `fall_tick`  out  CHANNELS  1-cycle strobe, high in the first cycle `clk_out` is 0
- `mid_tick`  out  CHANNELS  1-cycle strobe at the midpoint of each half-period
- `half_cur`  out  CHANNELS*CNT_W  active half-period per channel, channel i at bits [i*CNT_W +: CNT_W]

## Operation
- Each channel holds three registers:
  - the active half-period H;
  - a pending half-period P, with a pending flag;
  - the edge counter.
- Writes:
  - `div_wr[i]` with `div_data`=0 is stored as 1.
  - If channel i is disabled, the write goes straight into H.
  - If channel i is enabled, the write goes into P and sets the pending flag. H takes P at the next toggle of `clk_out`, so no truncated half-periods occur.
  - A write in the same cycle as a toggle is applied at that toggle.
  - A second write before the toggle overwrites P.
- Running, with `ch_en[i]`=1: `clk_out[i]` toggles every H cycles, giving period 2H.
  - `rise_tick` and `fall_tick` coincide with the new level.
  - `mid_tick` fires floor(H/2) cycles after each toggle, and after each start, when H≥2. It never fires when H=1.
- Start: on the first edge at which `ch_en[i]` is sampled 1 (edge E), the counter clears and `clk_out` stays at `IDLE_LEVEL`. The first toggle occurs at edge E+H.
- Disable: on the edge at which `ch_en[i]` is sampled 0:
  - `clk_out` returns to `IDLE_LEVEL` and the counter clears;
  - no rise/fall tick is generated for this return;
  - a pending P is moved into H.
- Sync: `sync_p` sampled 1 restarts every enabled channel exactly as a fresh start at that edge (same rules as E). Disabled channels ignore it. `sync_p` together with a rising `ch_en` is a single start.
- Reset values:
  - `clk_out` = `IDLE_LEVEL` on all bits;
  - all ticks 0;
  - counters 0;
  - H = `DEFAULT_HALF`;
  - pending flags clear.
- Reset asserted mid-period returns to the reset values immediately (asynchronously), with no tick.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Enable-to-first-edge latency is exactly H cycles.
- Tick strobes are exactly 1 cycle wide; rise and fall never coincide on one channel.
- With H=1, `clk_out` toggles every cycle and rise/fall alternate every cycle.
- Channels are fully independent except for the shared `div_data` bus and `sync_p`.
- The counter is CNT_W bits wide and compares against H-1; there is no wrap beyond H.

## Test plan
- Reset defaults: release reset, enable ch0 at edge 0 with H=125.
  - `clk_out[0]` rises at edge 125, falls at 250, rises at 375.
  - `rise_tick` high only at 125 and 375; `mid_tick` at 62, 187, 312.
- Small divisors:
  - write H=1 to ch1 while disabled, then enable: `clk_out[1]` toggles every cycle and `mid_tick[1]` stays 0;
  - write H=0: `half_cur` reads 1.
- Glitch-free reload: ch0 running with H=4, write 10 two cycles after a rise.
  - Current high phase still lasts 4 cycles.
  - The following low phase lasts 10 cycles; `half_cur` changes at that toggle.
- Disable mid-high-phase: with H=6, drop `ch_en` 3 cycles after a rise.
  - Next cycle `clk_out`=`IDLE_LEVEL`, no `fall_tick`.
  - Re-enable: first rise after exactly 6 cycles.
- Sync alignment: ch0 with H=5 and ch1 with H=5, started 2 cycles apart; pulse `sync_p`.
  - Both rise together 5 cycles later, with identical tick patterns thereafter.
  - A disabled ch2 stays idle.
- Async reset mid-operation: assert `reset_p` between clock edges while `clk_out`=1 and H=8 was loaded.
  - Outputs go to `IDLE_LEVEL` immediately, ticks 0.
  - After release, `half_cur` reads 125.
